// File: rtl/controle_saida_bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : controle_saida_bcd_pkg
//  Description : Shared definitions for the OUT-path BCD sequencer.
//                - c_WIDTH / c_DIGITS : default data width and BCD digit count
//                - c_BCD_W            : packed BCD width (4 bits per digit)
//                - state_t            : sequencer state encoding
//  Revision    : 1.0  initial release
// ============================================================================
package controle_saida_bcd_pkg;

    localparam int c_WIDTH  = 32;
    localparam int c_DIGITS = 10;   // enough decimal digits for 2^31
    localparam int c_BCD_W  = 4 * c_DIGITS;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/controle_saida_bcd_if.sv
`default_nettype none
// ============================================================================
//  Module      : controle_saida_bcd_if
//  Description : Request/display bundle of the OUT-path BCD sequencer.
//                master : requester (drives req, dados; observes the rest)
//                slave  : sequencer (observes req, dados; drives ready, busy,
//                         done, saida, segmentos, neg)
//  Revision    : 1.0  initial release
// ============================================================================
interface controle_saida_bcd_if
    import controle_saida_bcd_pkg::*;
#(
    parameter int WIDTH  = c_WIDTH,
    parameter int DIGITS = c_DIGITS
);

    logic                  req;
    logic [WIDTH-1:0]      dados;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [WIDTH-1:0]      saida;
    logic [4*DIGITS-1:0]   segmentos;
    logic                  neg;

    modport master (
        output req, dados,
        input  ready, busy, done, saida, segmentos, neg
    );

    modport slave (
        input  req, dados,
        output ready, busy, done, saida, segmentos, neg
    );

endinterface
`default_nettype wire

// File: rtl/controle_saida_bcd_step.sv
`default_nettype none
// ============================================================================
//  Module      : controle_saida_bcd_step
//  Description : One combinational double-dabble iteration.
//                i_bcd / i_mag : current BCD accumulator and binary magnitude
//                o_bcd / o_mag : accumulator after per-nibble add-3 and a
//                                one-bit left shift of the pair {bcd, mag}
//  Revision    : 1.0  initial release
// ============================================================================
module controle_saida_bcd_step #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic [4*DIGITS-1:0] i_bcd,
    input  logic [WIDTH-1:0]    i_mag,
    output logic [4*DIGITS-1:0] o_bcd,
    output logic [WIDTH-1:0]    o_mag
);

    localparam int BCD_W = 4 * DIGITS;

    logic [BCD_W-1:0] w_adj;

    // Add 3 to every digit >= 5; nibbles are independent, no carry between them.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign w_adj[4*d +: 4] = (i_bcd[4*d +: 4] >= 4'd5) ? (i_bcd[4*d +: 4] + 4'd3)
                                                           : i_bcd[4*d +: 4];
    end

    assign o_bcd = {w_adj[BCD_W-2:0], i_mag[WIDTH-1]};
    // The bit leaving the top of the accumulator is always 0 when DIGITS is
    // large enough, so it is recycled into the vacated magnitude LSB. A bit
    // entering there needs WIDTH more shifts to reach the accumulator, which
    // never happens within one conversion.
    assign o_mag = {i_mag[WIDTH-2:0], w_adj[BCD_W-1]};

endmodule
`default_nettype wire

// File: rtl/controle_saida_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : controle_saida_bcd
//  Description : OUT-path sequencer. Accepts a signed value, converts its
//                magnitude to packed BCD one double-dabble step per clock and
//                holds the display registers until the next conversion. A
//                one-entry pending buffer absorbs a request arriving mid-run.
//                clock, reset : clock and synchronous active-high reset
//                bus (slave)  : req/dados in; ready/busy/done/saida/
//                               segmentos/neg out
//  Revision    : 1.0  initial release
// ============================================================================
module controle_saida_bcd
    import controle_saida_bcd_pkg::*;
#(
    parameter int WIDTH  = c_WIDTH,
    parameter int DIGITS = c_DIGITS
) (
    input  logic                clock,
    input  logic                reset,
    controle_saida_bcd_if.slave bus
);

    localparam int                BCD_W  = 4 * DIGITS;
    localparam int                CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   r_bcd;
    logic [WIDTH-1:0]   r_mag;
    logic               r_neg_work;
    logic [WIDTH-1:0]   r_raw_work;
    logic               r_pend_valid;
    logic [WIDTH-1:0]   r_pend_data;
    logic               r_done;
    logic [WIDTH-1:0]   r_saida;
    logic [BCD_W-1:0]   r_seg;
    logic               r_neg;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [BCD_W-1:0]   w_bcd_nxt;
    logic [WIDTH-1:0]   w_mag_nxt;
    logic               w_neg_work_nxt;
    logic [WIDTH-1:0]   w_raw_work_nxt;
    logic               w_pend_valid_nxt;
    logic [WIDTH-1:0]   w_pend_data_nxt;
    logic               w_load;
    logic               w_commit;
    logic [WIDTH-1:0]   w_load_data;
    logic [BCD_W-1:0]   w_step_bcd;
    logic [WIDTH-1:0]   w_step_mag;

    controle_saida_bcd_step #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_step (
        .i_bcd  (r_bcd),
        .i_mag  (r_mag),
        .o_bcd  (w_step_bcd),
        .o_mag  (w_step_mag)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_bcd_nxt        = r_bcd;
        w_mag_nxt        = r_mag;
        w_neg_work_nxt   = r_neg_work;
        w_raw_work_nxt   = r_raw_work;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_data_nxt  = r_pend_data;
        w_load           = 1'b0;
        w_commit         = 1'b0;
        w_load_data      = bus.dados;

        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_CONV;
                end
            end
            ST_CONV: begin
                w_bcd_nxt = w_step_bcd;
                w_mag_nxt = w_step_mag;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == c_LAST) begin
                    // Last step: publish results and chain straight into the
                    // next conversion if one is waiting, pending buffer first.
                    w_commit = 1'b1;
                    if (r_pend_valid) begin
                        w_load           = 1'b1;
                        w_load_data      = r_pend_data;
                        w_pend_valid_nxt = 1'b0;
                    end else if (bus.req) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (bus.req && !r_pend_valid) begin
                    w_pend_valid_nxt = 1'b1;
                    w_pend_data_nxt  = bus.dados;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Load overrides the step results; magnitude wraps mod 2^WIDTH so the
        // most negative value converts as its unsigned magnitude.
        if (w_load) begin
            w_neg_work_nxt = w_load_data[WIDTH-1];
            w_mag_nxt      = w_load_data[WIDTH-1] ? ((~w_load_data) + WIDTH'(1)) : w_load_data;
            w_bcd_nxt      = '0;
            w_cnt_nxt      = '0;
            w_raw_work_nxt = w_load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt        <= '0;
            r_bcd        <= '0;
            r_mag        <= '0;
            r_neg_work   <= 1'b0;
            r_raw_work   <= '0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_done       <= 1'b0;
            r_saida      <= '0;
            r_seg        <= '0;
            r_neg        <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_bcd        <= w_bcd_nxt;
            r_mag        <= w_mag_nxt;
            r_neg_work   <= w_neg_work_nxt;
            r_raw_work   <= w_raw_work_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_data  <= w_pend_data_nxt;
            r_done       <= w_commit;
            if (w_commit) begin
                r_seg   <= w_step_bcd;
                r_neg   <= r_neg_work;
                r_saida <= r_raw_work;
            end
        end
    end

    assign bus.ready     = !r_pend_valid;
    assign bus.busy      = (r_state == ST_CONV);
    assign bus.done      = r_done;
    assign bus.saida     = r_saida;
    assign bus.segmentos = r_seg;
    assign bus.neg       = r_neg;

endmodule
`default_nettype wire

// File: tb/tb_controle_saida_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controle_saida_bcd
//  Description : Directed self-checking bench for controle_saida_bcd.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_controle_saida_bcd;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    controle_saida_bcd_if #(.WIDTH(32), .DIGITS(10)) bus ();

    controle_saida_bcd #(.WIDTH(32), .DIGITS(10)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge; returns just after acceptance edge.
    task automatic start(input logic [31:0] v);
        bus.req   = 1'b1;
        bus.dados = v;
        tick();
        bus.req   = 1'b0;
    endtask

    // Ticks until done is seen, bounded to 40 cycles.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.done && n < 40);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.saida !== 32'h0) begin failures++; $display("FAIL reset_saida got=%h exp=%h", bus.saida, 32'h0); end
        checks++; if (bus.segmentos !== 40'h0) begin failures++; $display("FAIL reset_seg got=%h exp=%h", bus.segmentos, 40'h0); end
        checks++; if (bus.neg !== 1'b0) begin failures++; $display("FAIL reset_neg got=%b exp=0", bus.neg); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n;
        start(32'd1234);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", bus.busy); end
        wait_done(n);
        checks++; if (n !== 32) begin failures++; $display("FAIL basic_latency got=%0d exp=32", n); end
        checks++; if (bus.segmentos !== 40'h0000001234) begin failures++; $display("FAIL basic_seg got=%h exp=%h", bus.segmentos, 40'h0000001234); end
        checks++; if (bus.neg !== 1'b0) begin failures++; $display("FAIL basic_neg got=%b exp=0", bus.neg); end
        checks++; if (bus.saida !== 32'd1234) begin failures++; $display("FAIL basic_saida got=%h exp=%h", bus.saida, 32'd1234); end
        tick();
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", bus.busy); end
    endtask

    task automatic test_neg_one();
        int n;
        start(32'hFFFFFFFF);
        wait_done(n);
        checks++; if (n !== 32) begin failures++; $display("FAIL m1_latency got=%0d exp=32", n); end
        checks++; if (bus.segmentos !== 40'h0000000001) begin failures++; $display("FAIL m1_seg got=%h exp=%h", bus.segmentos, 40'h0000000001); end
        checks++; if (bus.neg !== 1'b1) begin failures++; $display("FAIL m1_neg got=%b exp=1", bus.neg); end
        checks++; if (bus.saida !== 32'hFFFFFFFF) begin failures++; $display("FAIL m1_saida got=%h exp=%h", bus.saida, 32'hFFFFFFFF); end
        tick();
    endtask

    task automatic test_extremes();
        int n;
        start(32'h80000000);
        wait_done(n);
        checks++; if (bus.segmentos !== 40'h2147483648) begin failures++; $display("FAIL min_seg got=%h exp=%h", bus.segmentos, 40'h2147483648); end
        checks++; if (bus.neg !== 1'b1) begin failures++; $display("FAIL min_neg got=%b exp=1", bus.neg); end
        checks++; if (bus.saida !== 32'h80000000) begin failures++; $display("FAIL min_saida got=%h exp=%h", bus.saida, 32'h80000000); end
        tick();
        start(32'h7FFFFFFF);
        wait_done(n);
        checks++; if (bus.segmentos !== 40'h2147483647) begin failures++; $display("FAIL max_seg got=%h exp=%h", bus.segmentos, 40'h2147483647); end
        checks++; if (bus.neg !== 1'b0) begin failures++; $display("FAIL max_neg got=%b exp=0", bus.neg); end
        checks++; if (bus.saida !== 32'h7FFFFFFF) begin failures++; $display("FAIL max_saida got=%h exp=%h", bus.saida, 32'h7FFFFFFF); end
        tick();
    endtask

    task automatic test_zero_hold();
        int n;
        int bad;
        start(32'd0);
        wait_done(n);
        checks++; if (n !== 32) begin failures++; $display("FAIL zero_latency got=%0d exp=32", n); end
        checks++; if (bus.segmentos !== 40'h0) begin failures++; $display("FAIL zero_seg got=%h exp=%h", bus.segmentos, 40'h0); end
        checks++; if (bus.neg !== 1'b0) begin failures++; $display("FAIL zero_neg got=%b exp=0", bus.neg); end
        checks++; if (bus.saida !== 32'h0) begin failures++; $display("FAIL zero_saida got=%h exp=%h", bus.saida, 32'h0); end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.segmentos !== 40'h0 || bus.saida !== 32'h0 || bus.neg !== 1'b0
                || bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL zero_hold_stable got=%0d bad_cycles exp=0", bad); end
    endtask

    task automatic test_back_to_back();
        int n;
        int gap;
        start(32'd5);                     // accepted at E0
        repeat (9) tick();                // E1..E9
        bus.req   = 1'b1;
        bus.dados = 32'd77;
        tick();                           // E10: 77 captured into pending buffer
        checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_pend got=%b exp=0", bus.ready); end
        bus.dados = 32'd9;                // held request, ignored while not ready
        wait_done(n);                     // E32
        checks++; if (n !== 22) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=22", n); end
        checks++; if (bus.segmentos !== 40'h5) begin failures++; $display("FAIL b2b_seg5 got=%h exp=%h", bus.segmentos, 40'h5); end
        tick();                           // E33: 9 captured
        bus.req = 1'b0;
        checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_9 got=%b exp=0", bus.ready); end
        wait_done(n);
        gap = n + 1;
        checks++; if (gap !== 32) begin failures++; $display("FAIL b2b_gap1 got=%0d exp=32", gap); end
        checks++; if (bus.segmentos !== 40'h77) begin failures++; $display("FAIL b2b_seg77 got=%h exp=%h", bus.segmentos, 40'h77); end
        wait_done(n);
        checks++; if (n !== 32) begin failures++; $display("FAIL b2b_gap2 got=%0d exp=32", n); end
        checks++; if (bus.segmentos !== 40'h9) begin failures++; $display("FAIL b2b_seg9 got=%h exp=%h", bus.segmentos, 40'h9); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", bus.busy); end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        start(32'd5);                     // E0
        repeat (4) tick();                // E1..E4
        bus.req   = 1'b1;
        bus.dados = 32'd77;
        tick();                           // E5: pending captured
        bus.req   = 1'b0;
        repeat (10) tick();               // E6..E15: cnt=15
        checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL rmid_pending got=%b exp=0", bus.ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.saida !== 32'h0) begin failures++; $display("FAIL rmid_saida got=%h exp=%h", bus.saida, 32'h0); end
        checks++; if (bus.segmentos !== 40'h0) begin failures++; $display("FAIL rmid_seg got=%h exp=%h", bus.segmentos, 40'h0); end
        checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", bus.ready); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rmid_done got=%b exp=0", bus.done); end
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rmid_no_done got=%0d active_cycles exp=0", seen); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.req   = 1'b0;
        bus.dados = 32'h0;
        test_reset();
        test_basic();
        test_neg_one();
        test_extremes();
        test_zero_hold();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
